// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage for a single-cycle MIPS core. It owns the PC and fetches one
// instruction at a time over a request/valid handshake. It holds that word
// for decode/execute. When execute signals completion, it computes the next
// PC from the decoder's PCSrc/Branch outcome. It also counts retired
// instructions and traps misaligned control transfers (sticky until reset).
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   imem_req     fetch request to instruction memory (high throughout FETCH)
//   imem_addr    fetch byte address (always equals pc)
//   imem_rvalid  instruction memory read data valid
//   imem_rdata   instruction word from memory
//   instr_valid  instr/pc/pc_plus4 hold a valid instruction (HOLD)
//   instr        held instruction ([31:26] OpCode, [5:0] Funct)
//   pc           address of the held instruction
//   pc_plus4     pc + 4, wraps mod 2^32 (link value for jal/jalr)
//   instr_ready  execute done; retire the held instruction this cycle
//   pc_src       decoder PCSrc: 00 seq/branch, 01 j/jal, 10 jr/jalr, 11 rsvd
//   branch       decoder Branch
//   zero         ALU zero flag; branch taken when branch && zero
//   jr_target    register rs value for jr/jalr
//   fault        misaligned next-PC trap, sticky until reset
//   retired      retired-instruction count, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             instr_ready,
  input  logic [1:0]       pc_src,
  input  logic             branch,
  input  logic             zero,
  input  logic [31:0]      jr_target,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  // Set once the request has been up for a full cycle. Memory data is only
  // accepted from the second FETCH cycle onward, so a response can never
  // arrive in the same cycle the request first rises.
  logic        fetch_armed;

  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        load_instr;
  logic        do_retire;
  logic        next_misaligned;

  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Next-PC selection. PCSrc takes priority over the branch outcome.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would otherwise infer a latch.
    next_pc = pc_plus4;
    unique case (pc_src)
      2'b01:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b10:   next_pc = jr_target;
      2'b11:   next_pc = pc_plus4;
      default: if (branch && zero) next_pc = pc_plus4 + branch_off;
    endcase
  end

  assign next_misaligned = (next_pc[1:0] != 2'b00);
  assign load_instr      = (state == FETCH) && fetch_armed && imem_rvalid;
  assign do_retire       = (state == HOLD) && instr_ready && !next_misaligned;

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (load_instr) state_next = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) state_next = next_misaligned ? FAULT : FETCH;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_armed <= 1'b0;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      retired     <= '0;
    end else begin
      state       <= state_next;
      fetch_armed <= (state == FETCH) && (state_next == FETCH);
      if (load_instr) instr <= imem_rdata;
      if (do_retire) begin
        pc      <= next_pc;
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle MIPS control decoder.
- Owns the PC and fetches each instruction from instruction memory over a request/valid handshake.
- Presents the held instruction (OpCode/Funct source) to decode/execute, then computes the next PC from the decoder's PCSrc/Branch outcome when the instruction retires.
- Counts retired instructions and traps misaligned control transfers.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch byte address; equals pc.
- imem_rvalid  in  1  instruction memory read data valid.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/pc outputs hold a valid instruction.
- instr  out  32  held instruction; [31:26] feeds OpCode, [5:0] feeds Funct.
- pc  out  32  address of held instruction.
- pc_plus4  out  32  pc+4, mod 2^32, used for jal/jalr link.
- instr_ready  in  1  execute done; retire the held instruction this cycle.
- pc_src  in  2  decoder PCSrc: 00 sequential/branch, 01 j/jal, 10 jr/jalr, 11 reserved.
- branch  in  1  decoder Branch.
- zero  in  1  ALU zero flag; branch taken when branch&&zero.
- jr_target  in  32  register rs value for jr/jalr.
- fault  out  1  misaligned next-PC trap, sticky.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE, FETCH, HOLD, FAULT. Reset asserted → state IDLE, pc=RESET_PC, instr=0, retired=0. imem_req=0, instr_valid=0, fault=0 (all outputs registered or decoded from state).
- IDLE → FETCH unconditionally on the first clock after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_rvalid.
  - Data is accepted no earlier than the cycle after imem_req first rises.
  - On imem_rvalid: instr←imem_rdata, go to HOLD.
- HOLD:
  - instr_valid=1, imem_req=0. instr, pc and pc_plus4 are stable for the whole of HOLD.
  - On instr_ready, compute next_pc from the held instr and the current pc:
    - pc_src=01: {pc_plus4[31:28], instr[25:0], 2'b00}.
    - pc_src=10: jr_target.
    - pc_src=11: pc_plus4.
    - Else if branch&&zero: pc_plus4 + (sign_ext(instr[15:0])<<2), mod 2^32.
    - Else: pc_plus4.
    - pc_src has priority over branch.
  - If next_pc[1:0]==2'b00: pc←next_pc, retired←retired+1 (wraps at 2^CNT_W), go to FETCH. Next fetch request is asserted the cycle after retire.
  - If next_pc[1:0]!=2'b00: go to FAULT. pc and retired are unchanged, fault=1.
- FAULT: imem_req=0, instr_valid=0, fault=1. Exits only via reset.
- Ignored inputs:
  - imem_rvalid is ignored outside FETCH.
  - instr_ready is ignored outside HOLD.
  - pc_src, branch, zero and jr_target are sampled only when instr_ready is high in HOLD.
- pc arithmetic wraps: pc=32'hFFFF_FFFC sequential → 32'h0000_0000.
- Reset mid-operation (any state) returns to IDLE immediately. The instruction memory shares this reset, so there are no stale responses.
- Minimum throughput: 3 cycles per instruction (FETCH with 1-cycle memory, HOLD, retire edge).

Test Plan:
- Reset release, memory returns 32'h2008_0005 one cycle after request → imem_addr=0x00400000 in FETCH. Then instr_valid=1, instr=0x20080005, pc_plus4=0x00400004. After instr_ready with pc_src=00, branch=0: pc=0x00400004, retired=1.
- beq at pc=0x00400010 with imm 16'hFFFE, branch=1, zero=1 → next pc=0x0040000C. Same with zero=0 → 0x00400014.
- j instr 32'h0810_0004 at pc=0x00400020, pc_src=01 → pc=0x00400010. Same word with branch=1, zero=1 still gives 0x00400010 (priority check).
- jr with pc_src=10, jr_target=0x00400006 → fault=1, pc stays at the old value, retired unchanged. Subsequent imem_rvalid/instr_ready pulses cause no change until reset.
- pc=0xFFFFFFFC sequential retire → pc=0x00000000, imem_addr=0. Memory with 4-cycle latency → imem_req/imem_addr stable for all 4 cycles.
- Reset asserted while in HOLD with instr_ready=1 → outputs immediately return to reset values. pc=RESET_PC after release, retired=0.
